// File: rtl/uart_command_receiver.sv
// 8N1 UART receiver for the host command link: synchronised RX, mid-bit sampling,
// start-glitch rejection and stop-bit framing check, with registered byte/strobe outputs.
module uart_command_receiver #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int INT_WIDTH    = 8
) (
    input  logic                 MESSAGE_INTERPRETER_CLOCK_50,
    input  logic                 MESSAGE_INTERPRETER_RESET_InHigh,
    input  logic                 UART_RX_In,
    output logic [INT_WIDTH-1:0] UART_DATA_OutBus,
    output logic                 UART_FLAGDATA_OutHigh,
    output logic                 UART_FRAMEERR_OutHigh,
    output logic                 UART_BUSY_OutHigh
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(INT_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_idx;
    logic [INT_WIDTH-1:0]   shift;

    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    logic [1:0]             sync_fill;
    logic                   armed;
    logic                   start_edge;

    // armed only rises once the synchroniser carries a real pin sample that is high,
    // so a line held low through reset release is never mistaken for a start bit.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge MESSAGE_INTERPRETER_CLOCK_50 or posedge MESSAGE_INTERPRETER_RESET_InHigh) begin
        if (MESSAGE_INTERPRETER_RESET_InHigh) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= UART_RX_In;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = armed && rx_prev && !rx_s;

    always_ff @(posedge MESSAGE_INTERPRETER_CLOCK_50 or posedge MESSAGE_INTERPRETER_RESET_InHigh) begin
        if (MESSAGE_INTERPRETER_RESET_InHigh) begin
            state                 <= ST_IDLE;
            bit_cnt               <= '0;
            bit_idx               <= '0;
            shift                 <= '0;
            UART_DATA_OutBus      <= '0;
            UART_FLAGDATA_OutHigh <= 1'b0;
            UART_FRAMEERR_OutHigh <= 1'b0;
            UART_BUSY_OutHigh     <= 1'b0;
        end else begin
            UART_FLAGDATA_OutHigh <= 1'b0;
            UART_FRAMEERR_OutHigh <= 1'b0;

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (start_edge) begin
                        state             <= ST_START;
                        UART_BUSY_OutHigh <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_cnt == HALF) begin
                        bit_cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                        end else begin
                            state             <= ST_IDLE;
                            UART_BUSY_OutHigh <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        shift   <= {rx_s, shift[INT_WIDTH-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                // Leaving at mid-stop gives half a bit of margin for a back-to-back start bit.
                ST_STOP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            UART_DATA_OutBus      <= shift;
                            UART_FLAGDATA_OutHigh <= 1'b1;
                            UART_BUSY_OutHigh     <= 1'b0;
                            state                 <= ST_IDLE;
                        end else begin
                            UART_FRAMEERR_OutHigh <= 1'b1;
                            state                 <= ST_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    if (rx_s) begin
                        state             <= ST_IDLE;
                        UART_BUSY_OutHigh <= 1'b0;
                    end
                end

                default: begin
                    state             <= ST_IDLE;
                    UART_BUSY_OutHigh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_command_receiver.sv
// Scoreboard bench for uart_command_receiver: directed scenarios plus randomized
// frames, with expected strobes queued by the driver and checked by an independent monitor.
module tb_uart_command_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       flag;
    logic       ferr;
    logic       busy;

    always #10 clk = ~clk;

    uart_command_receiver #(
        .CLKS_PER_BIT (CPB),
        .INT_WIDTH    (8)
    ) dut (
        .MESSAGE_INTERPRETER_CLOCK_50     (clk),
        .MESSAGE_INTERPRETER_RESET_InHigh (rst),
        .UART_RX_In                       (rx),
        .UART_DATA_OutBus                 (data),
        .UART_FLAGDATA_OutHigh            (flag),
        .UART_FRAMEERR_OutHigh            (ferr),
        .UART_BUSY_OutHigh                (busy)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         flag_cyc[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] exp_last = 8'h00;
    logic       prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after each rising edge and retires queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (flag && ferr) check("both_strobes", 1, 0);
                if (flag || ferr) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", {flag, ferr}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", ferr, e.err);
                        if (!e.err) begin
                            check("rx_byte", data, e.data);
                            check("busy_low_on_flag", busy, 0);
                            check("busy_before_flag", prev_busy, 1);
                            exp_last = e.data;
                            flag_cyc.push_back(cyc);
                        end else begin
                            check("byte_held_on_ferr", data, exp_last);
                            check("busy_in_break", busy, 1);
                        end
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic v, input int n);
        rx = v;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        e.err  = !stop_ok;
        e.data = b;
        exp_q.push_back(e);
        send_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bits(b[i], CPB);
        if (stop_ok) begin
            send_bits(1'b1, CPB);
        end else begin
            send_bits(1'b0, 2 * CPB);
            check("busy_held_in_break", busy, 1);
            send_bits(1'b1, 6);
            check("busy_after_break", busy, 0);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int   n0;
        bit   seen;
        logic [7:0] b;
        int   r;

        rx  = 1'b1;
        rst = 1'b1;
        wait_clks(5);
        check("reset_data", data, 8'h00);
        check("reset_flag", flag, 0);
        check("reset_ferr", ferr, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        wait_clks(20);

        // Single frame: x_i query byte.
        send_frame(8'h14, 1'b1);
        send_bits(1'b1, 10);
        wait_drain();
        check("data_held_14", data, 8'h14);

        // Back-to-back frames with no idle gap.
        n0 = flag_cyc.size();
        send_frame(8'h01, 1'b1);
        send_frame(8'h0A, 1'b1);
        send_bits(1'b1, 10);
        wait_drain();
        if (flag_cyc.size() >= n0 + 2) check("b2b_spacing", flag_cyc[n0+1] - flag_cyc[n0], 160);
        else check("b2b_pulses", flag_cyc.size() - n0, 2);

        // Framing error with a stop bit held low for two bit-times.
        send_frame(8'hA5, 1'b0);
        send_bits(1'b1, 10);
        wait_drain();
        check("data_after_ferr", data, 8'h0A);

        // Short low glitch must be rejected.
        seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) rx = 1'b1;
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_pulse", seen, 1);
        check("glitch_back_idle", busy, 0);
        send_frame(8'h09, 1'b1);
        send_bits(1'b1, 10);
        wait_drain();

        // Asynchronous reset during data bit 4 of 0xFF.
        n0 = flag_cyc.size();
        send_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bits(1'b1, CPB);
        send_bits(1'b1, 8);
        check("busy_mid_frame", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_flag", flag, 0);
        check("midrst_ferr", ferr, 0);
        check("midrst_busy", busy, 0);
        exp_last = 8'h00;
        wait_clks(3);
        rst = 1'b0;
        send_bits(1'b1, 4 * CPB + 5);
        check("no_flag_after_reset", flag_cyc.size(), n0);
        send_frame(8'h0A, 1'b1);
        send_bits(1'b1, 10);
        wait_drain();
        check("data_after_reset_frame", data, 8'h0A);
        check("one_flag_after_reset", flag_cyc.size(), n0 + 1);

        // Line held low while reset releases.
        rx  = 1'b0;
        rst = 1'b1;
        wait_clks(3);
        exp_last = 8'h00;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("no_start_from_low_line", seen, 0);
        send_bits(1'b1, 10);
        send_frame(8'h33, 1'b1);
        send_bits(1'b1, 10);
        wait_drain();

        // Randomized traffic: good frames, framing errors, glitches, varied gaps.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rx = 1'b0;
                wait_clks(int'($urandom_range(1, 6)));
                send_bits(1'b1, 14);
            end else begin
                b = 8'($urandom_range(0, 255));
                send_frame(b, r != 1);
                send_bits(1'b1, int'($urandom_range(0, 12)));
            end
        end
        send_bits(1'b1, 10);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_command_receiver.md
# uart_command_receiver

- UART receiver (8N1) that deserialises the command byte stream from the host radio/serial link.
- Produces the 8-bit byte and the one-cycle valid strobe that drive the message interpreter's `FLAGDATAIN`/`DATAIN` inputs.
- Uses mid-bit sampling with a 2-FF input synchroniser, start-bit glitch rejection and stop-bit framing check.
- Sits between the board RX pin and the message interpreter.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud); legal range ≥ 8.
- INT_WIDTH, 8: data byte width; fixed at 8 for 8N1.

Ports:
- MESSAGE_INTERPRETER_CLOCK_50  in  1  system clock, 50 MHz.
- MESSAGE_INTERPRETER_RESET_InHigh  in  1  asynchronous, active-high reset.
- UART_RX_In  in  1  serial line, idle high, asynchronous to the clock.
- UART_DATA_OutBus  out  INT_WIDTH  last correctly received byte; held until the next good byte.
- UART_FLAGDATA_OutHigh  out  1  one-cycle strobe; `UART_DATA_OutBus` is valid on the same cycle.
- UART_FRAMEERR_OutHigh  out  1  one-cycle strobe when the stop bit is sampled low.
- UART_BUSY_OutHigh  out  1  high while state ≠ IDLE.

## Operation
- **Synchroniser:** two flops on UART_RX_In give rx_s. Both flops reset to 1. A third flop holds rx_prev for edge detection and also resets to 1.
- **Counters:**
  - Bit-timer counter, width ceil(log2(CLKS_PER_BIT)).
  - 3-bit bit index.
  - 8-bit shift register; data arrives LSB first and is right-shifted in.
- **Constant:** HALF = (CLKS_PER_BIT-1)/2, integer division.
- **IDLE:** counter = 0, index = 0. When rx_prev = 1 and rx_s = 0 (falling edge), go to START.
  - A line that is low when leaving reset is never taken as a start bit; it must first return high.
- **START:** counter increments each cycle. At counter = HALF, sample rx_s:
  - rx_s = 0: go to DATA with counter cleared.
  - rx_s = 1: glitch; go to IDLE. No strobe is produced.
- **DATA:** at counter = CLKS_PER_BIT-1:
  - Sample rx_s into shift[7] (after shifting right), clear counter, increment index.
  - After index 7 has been sampled, go to STOP with index cleared.
- **STOP:** at counter = CLKS_PER_BIT-1, sample rx_s:
  - rx_s = 1: load UART_DATA_OutBus from the shift register, pulse UART_FLAGDATA_OutHigh, go to IDLE.
  - rx_s = 0: pulse UART_FRAMEERR_OutHigh, leave UART_DATA_OutBus unchanged, go to BREAK.
- **BREAK:** wait until rx_s = 1, then go to IDLE. This stops a held-low line (break condition) from being read as repeated 0x00 frames.
- **Strobes:** FLAGDATA and FRAMEERR are never high on the same cycle. Each is high for exactly one cycle per frame.
- **Back-to-back frames:** a start bit that immediately follows a stop bit must be received. Returning to IDLE at mid-stop leaves half a bit of margin.

## Timing
- **Reset values:**
  - UART_DATA_OutBus = 0x00.
  - UART_FLAGDATA_OutHigh = 0, UART_FRAMEERR_OutHigh = 0, UART_BUSY_OutHigh = 0.
  - State = IDLE, counter = 0, index = 0, shift = 0x00.
- **Reset mid-frame:** all of the above take effect immediately (asynchronously). The partial byte is discarded and no strobe is produced.
- **Sample points**, with T0 = first cycle with state = START and counter = 0:
  - Start-bit check at T0+HALF.
  - Data bit k (0..7) at T0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit at T0+HALF+9·CLKS_PER_BIT.
- **Strobe timing:**
  - FLAGDATA (or FRAMEERR) and the new UART_DATA_OutBus value are registered, so they are visible the cycle after the stop sample.
  - BUSY is high from T0 through the stop-sample cycle, and through the end of BREAK.
- **Pin-to-state latency:** 3 clock cycles from the pin's falling edge to T0 (2 synchroniser flops plus 1 edge/state flop).
- **Ordering:** the downstream interpreter registers on the FLAGDATA cycle, so the byte must be stable on that cycle. This holds because DATA and FLAG update together.

## Test plan
Benches run with CLKS_PER_BIT = 16 (HALF = 7).
- **Single frame:** send 0x14 (x_i query) at 16 clk/bit → one FLAGDATA pulse; DATA = 0x14 on the pulse cycle and held afterwards; FRAMEERR never asserts; BUSY drops the cycle after the stop sample.
- **Back-to-back frames:** send 0x01 then 0x0A with no idle gap between the stop bit and the next start bit → two FLAGDATA pulses 160 cycles apart, carrying 0x01 then 0x0A.
- **Framing error:** send 0xA5 with the stop bit driven low for 2 bit-times, then idle → FRAMEERR pulses once, no FLAGDATA, DATA keeps its previous value (0x0A), BUSY stays high until the line returns high.
- **Glitch rejection:** drive RX low for 4 cycles and then high → BUSY pulses, no FLAGDATA or FRAMEERR, state returns to IDLE, and a following 0x09 frame is received correctly.
- **Reset mid-frame:** assert reset during data bit 4 of 0xFF → outputs go to 0x00/0/0/0 immediately; after release the rest of the aborted frame yields no FLAGDATA; then a full 0x0A frame → DATA = 0x0A with exactly one FLAGDATA.
- **Line low at reset release:** hold RX low while reset releases → no start detected until RX goes high and then falls again.
